// File: rtl/trace_pkg.sv
// Shared encodings for the commit trace checker.
// Entry layout is {pc, waddr, wdata}.
package trace_pkg;

  localparam int ENTRY_W   = 69;
  localparam int PC_MSB    = 68;
  localparam int PC_LSB    = 37;
  localparam int WADDR_MSB = 36;
  localparam int WADDR_LSB = 32;
  localparam int WDATA_MSB = 31;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } state_e;

  localparam logic [1:0] CAUSE_NONE = 2'd0;
  localparam logic [1:0] CAUSE_DATA = 2'd1;
  localparam logic [1:0] CAUSE_PC   = 2'd2;
  localparam logic [1:0] CAUSE_TO   = 2'd3;

endpackage

// File: rtl/trace_gold_ram.sv
// Golden trace storage: synchronous write,
// asynchronous read.
module trace_gold_ram
  import trace_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic               clk_i,
  input  logic               we_i,
  input  logic [AW-1:0]      waddr_i,
  input  logic [ENTRY_W-1:0] wdata_i,
  input  logic [AW-1:0]      raddr_i,
  output logic [ENTRY_W-1:0] rdata_o
);

  logic [ENTRY_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/commit_trace_checker.sv
// Compares writeback-port commits against a
// preloaded golden trace.
module commit_trace_checker
  import trace_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int AW      = 10,
  parameter int TIMEOUT = 4096
) (
  input  logic               clk_in,
  input  logic               reset,
  input  logic               gold_wena,
  input  logic [AW-1:0]      gold_addr,
  input  logic [ENTRY_W-1:0] gold_data,
  input  logic [AW:0]        gold_count,
  input  logic               start,
  input  logic               wb_wena,
  input  logic [4:0]         wb_waddr,
  input  logic [31:0]        wb_wdata,
  input  logic [31:0]        wb_pc,
  output logic               busy,
  output logic               pass,
  output logic               fail,
  output logic [1:0]         fail_cause,
  output logic [AW-1:0]      fail_index,
  output logic [ENTRY_W-1:0] fail_got,
  output logic [AW:0]        commit_cnt
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [AW-1:0]      ptr_q, ptr_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic [AW:0]        cnt_q, cnt_d;
  logic [AW:0]        ccnt_q, ccnt_d;
  logic               pass_q, pass_d;
  logic               fail_q, fail_d;
  logic [1:0]         cause_q, cause_d;
  logic [AW-1:0]      findex_q, findex_d;
  logic [ENTRY_W-1:0] fgot_q, fgot_d;

  logic [ENTRY_W-1:0] exp;
  logic [ENTRY_W-1:0] obs;
  logic               commit;
  logic               ad_bad;
  logic               pc_bad;
  logic               last;

  trace_gold_ram #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_ram (
    .clk_i  (clk_in),
    .we_i   (gold_wena && (state_q == ST_IDLE)),
    .waddr_i(gold_addr),
    .wdata_i(gold_data),
    .raddr_i(ptr_q),
    .rdata_o(exp)
  );

  assign obs    = {wb_pc, wb_waddr, wb_wdata};
  assign commit = wb_wena && (wb_waddr != 5'd0);
  assign ad_bad = obs[WADDR_MSB:0] != exp[WADDR_MSB:0];
  assign pc_bad = obs[PC_MSB:PC_LSB] != exp[PC_MSB:PC_LSB];
  assign last   = ({1'b0, ptr_q} + 1'b1) == cnt_q;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    timer_d  = timer_q;
    cnt_d    = cnt_q;
    ccnt_d   = ccnt_q;
    pass_d   = pass_q;
    fail_d   = fail_q;
    cause_d  = cause_q;
    findex_d = findex_q;
    fgot_d   = fgot_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          cnt_d   = gold_count;
          ptr_d   = '0;
          timer_d = '0;
          if (gold_count == '0) begin
            state_d = ST_PASS;
            pass_d  = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (commit) begin
          timer_d = '0;
          if (ad_bad || pc_bad) begin
            state_d  = ST_FAIL;
            fail_d   = 1'b1;
            cause_d  = ad_bad ? CAUSE_DATA : CAUSE_PC;
            findex_d = ptr_q;
            fgot_d   = obs;
          end else begin
            ccnt_d = ccnt_q + 1'b1;
            // Pointer stays on the final entry.
            if (last) begin
              state_d = ST_PASS;
              pass_d  = 1'b1;
            end else begin
              ptr_d = ptr_q + 1'b1;
            end
          end
        end else if (timer_q == TMAX) begin
          state_d  = ST_FAIL;
          fail_d   = 1'b1;
          cause_d  = CAUSE_TO;
          findex_d = ptr_q;
          fgot_d   = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      timer_q  <= '0;
      cnt_q    <= '0;
      ccnt_q   <= '0;
      pass_q   <= 1'b0;
      fail_q   <= 1'b0;
      cause_q  <= CAUSE_NONE;
      findex_q <= '0;
      fgot_q   <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      timer_q  <= timer_d;
      cnt_q    <= cnt_d;
      ccnt_q   <= ccnt_d;
      pass_q   <= pass_d;
      fail_q   <= fail_d;
      cause_q  <= cause_d;
      findex_q <= findex_d;
      fgot_q   <= fgot_d;
    end
  end

  assign busy       = state_q == ST_RUN;
  assign pass       = pass_q;
  assign fail       = fail_q;
  assign fail_cause = cause_q;
  assign fail_index = findex_q;
  assign fail_got   = fgot_q;
  assign commit_cnt = ccnt_q;

endmodule

// File: tb/tb_commit_trace_checker.sv
// Randomized scoreboard bench for the commit
// trace checker against a queue-based model.
module tb_commit_trace_checker;

  localparam int DEPTH   = 16;
  localparam int AW      = 4;
  localparam int TIMEOUT = 16;

  logic          clk_in = 1'b0;
  logic          reset = 1'b1;
  logic          gold_wena = 1'b0;
  logic [AW-1:0] gold_addr = '0;
  logic [68:0]   gold_data = '0;
  logic [AW:0]   gold_count = '0;
  logic          start = 1'b0;
  logic          wb_wena = 1'b0;
  logic [4:0]    wb_waddr = '0;
  logic [31:0]   wb_wdata = '0;
  logic [31:0]   wb_pc = '0;
  logic          busy, pass, fail;
  logic [1:0]    fail_cause;
  logic [AW-1:0] fail_index;
  logic [68:0]   fail_got;
  logic [AW:0]   commit_cnt;

  always #5 clk_in = ~clk_in;

  commit_trace_checker #(
    .DEPTH(DEPTH), .AW(AW), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_in(clk_in), .reset(reset),
    .gold_wena(gold_wena), .gold_addr(gold_addr),
    .gold_data(gold_data), .gold_count(gold_count),
    .start(start), .wb_wena(wb_wena),
    .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .wb_pc(wb_pc), .busy(busy), .pass(pass),
    .fail(fail), .fail_cause(fail_cause),
    .fail_index(fail_index), .fail_got(fail_got),
    .commit_cnt(commit_cnt)
  );

  typedef struct packed {
    logic          busy;
    logic          pass;
    logic          fail;
    logic [1:0]    cause;
    logic [AW-1:0] idx;
    logic [68:0]   got;
    logic [AW:0]   cnt;
  } snap_t;

  snap_t exq[$];
  int    checks = 0;
  int    errors = 0;
  string phase = "reset";

  // Model: 0 idle, 1 running, 2 passed, 3 failed
  int          mode = 0;
  logic [68:0] gm [DEPTH];
  logic [68:0] pending[$];
  int          matched = 0;
  int          quiet = 0;
  snap_t       m = '0;

  localparam logic [68:0] G0 = {32'h00400000, 5'd1, 32'h00000005};
  localparam logic [68:0] G1 = {32'h00400004, 5'd2, 32'h0000000A};
  localparam logic [68:0] G2 = {32'h00400008, 5'd3, 32'h0000000F};

  task automatic m_fail(input logic [1:0] c, input logic [68:0] g);
    mode    = 3;
    m.fail  = 1'b1;
    m.cause = c;
    m.idx   = AW'(matched);
    m.got   = g;
  endtask

  task automatic model_step();
    logic [68:0] o;
    logic [68:0] e;
    o = {wb_pc, wb_waddr, wb_wdata};
    if (reset) begin
      mode = 0; m = '0; matched = 0; quiet = 0;
      pending.delete();
    end else if (mode == 0) begin
      if (gold_wena) gm[gold_addr] = gold_data;
      if (start) begin
        pending.delete();
        for (int i = 0; i < int'(gold_count); i++)
          pending.push_back(gm[i]);
        matched = 0; quiet = 0;
        if (gold_count == 0) begin
          mode = 2; m.pass = 1'b1;
        end else begin
          mode = 1;
        end
      end
    end else if (mode == 1) begin
      if (wb_wena && wb_waddr != 5'd0) begin
        quiet = 0;
        e = pending[0];
        if (o[36:0] != e[36:0]) m_fail(2'd1, o);
        else if (o[68:37] != e[68:37]) m_fail(2'd2, o);
        else begin
          void'(pending.pop_front());
          matched++;
          if (pending.size() == 0) begin
            mode = 2; m.pass = 1'b1;
          end
        end
      end else begin
        quiet++;
        if (quiet == TIMEOUT) m_fail(2'd3, '0);
      end
    end
    m.cnt  = (AW+1)'(matched);
    m.busy = (mode == 1);
  endtask

  always @(posedge clk_in) begin : monitor
    snap_t e;
    snap_t a;
    #1;
    a = '{busy, pass, fail, fail_cause,
          fail_index, fail_got, commit_cnt};
    checks++;
    if (exq.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty phase=%s t=%0t", phase, $time);
    end else begin
      e = exq.pop_front();
      if (a !== e) begin
        errors++;
        $display("FAIL %s t=%0t got b%0b p%0b f%0b c%0d i%0d g%h n%0d exp b%0b p%0b f%0b c%0d i%0d g%h n%0d",
          phase, $time, a.busy, a.pass, a.fail, a.cause, a.idx, a.got, a.cnt,
          e.busy, e.pass, e.fail, e.cause, e.idx, e.got, e.cnt);
      end
    end
  end

  task automatic tick();
    model_step();
    exq.push_back(m);
    @(negedge clk_in);
    reset = 1'b0; start = 1'b0;
    gold_wena = 1'b0; wb_wena = 1'b0;
    wb_waddr = 5'($urandom);
    wb_wdata = $urandom;
    wb_pc = $urandom;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
  endtask

  task automatic load(input int i, input logic [68:0] e);
    gold_wena = 1'b1;
    gold_addr = AW'(i);
    gold_data = e;
    tick();
  endtask

  task automatic start_run(input int n);
    gold_count = (AW+1)'(n);
    start = 1'b1;
    tick();
  endtask

  task automatic commit(input logic [68:0] e);
    wb_wena = 1'b1;
    {wb_pc, wb_waddr, wb_wdata} = e;
    tick();
  endtask

  task automatic zero_commit();
    wb_wena = 1'b1;
    wb_waddr = 5'd0;
    tick();
  endtask

  initial begin
    logic [68:0] tr [8];
    logic [68:0] e;
    int n, k, sel;
    phase = "reset";
    do_reset(); do_reset();
    idle(2);

    phase = "match";
    load(0, G0); load(1, G1); load(2, G2);
    start_run(3);
    idle(2);
    commit(G0); zero_commit();
    commit(G1); idle(1);
    commit(G2); idle(2);
    load(0, 69'h1); start_run(1); commit(G0);
    idle(2);

    phase = "data_mismatch";
    do_reset(); start_run(3);
    commit(G0);
    commit({32'h00400004, 5'd2, 32'h0000000B});
    commit(G2); commit(G1);
    idle(2);

    phase = "pc_mismatch";
    do_reset(); start_run(3);
    zero_commit();
    commit({32'h00400010, 5'd1, 32'h00000005});
    idle(2);

    phase = "timeout";
    do_reset(); start_run(2);
    idle(20);
    do_reset(); start_run(2);
    idle(15); commit(G0);
    idle(20);

    phase = "zero_count";
    do_reset(); start_run(0);
    idle(2);

    phase = "wena_in_run";
    do_reset(); start_run(3);
    load(0, {32'hDEAD0000, 5'd9, 32'h12345678});
    start_run(1);
    commit(G0); commit(G1); commit(G2);
    do_reset(); start_run(3);
    commit(G0); commit(G1); commit(G2);
    idle(1);

    phase = "reset_mid_run";
    do_reset(); start_run(3);
    commit(G0);
    do_reset(); idle(1);
    start_run(3);
    commit(G0); commit(G1); commit(G2);
    idle(1);

    phase = "random";
    for (int r = 0; r < 30; r++) begin
      do_reset();
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) begin
        tr[i] = {32'($urandom), 5'($urandom_range(1, 31)), 32'($urandom)};
        load(i, tr[i]);
      end
      start_run(n);
      k = 0;
      for (int c = 0; c < 50; c++) begin
        sel = $urandom_range(0, 99);
        if (sel < 55 && k < n) begin
          commit(tr[k]); k++;
        end else if (sel < 63) begin
          e = tr[(k < n) ? k : 0];
          case ($urandom_range(0, 2))
            0: e[31:0] ^= 32'($urandom_range(1, 255));
            1: e[36:32] ^= 5'($urandom_range(1, 31));
            default: e[68:37] ^= 32'($urandom_range(1, 255));
          endcase
          commit(e);
        end else if (sel < 70) begin
          zero_commit();
        end else if (sel < 73) begin
          idle(18);
        end else if (sel < 80) begin
          gold_wena = 1'b1;
          gold_addr = AW'($urandom);
          gold_data = {$urandom, 5'($urandom), $urandom};
          gold_count = (AW+1)'($urandom);
          start = 1'($urandom);
          tick();
        end else begin
          tick();
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
